// File: rtl/tangram_move_ctrl.sv
// Tangram piece manipulation controller: owns the piece position/rotation table and applies
// move/rotate requests once per video frame so the display never reads a half-updated entry.
module tangram_move_ctrl #(
    parameter int N_PIECES        = 7,
    parameter int COORD_W         = 11,
    parameter int FRAMES_PER_STEP = 4,
    parameter int STEP_PX         = 4,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 760,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 560,
    parameter int INIT_PITCH      = 100
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                frame_start,
    input  logic [N_PIECES-1:0] sel,
    input  logic [3:0]          move,
    input  logic                rotate,
    input  logic [2:0]          rd_id,
    output logic [COORD_W-1:0]  rd_x,
    output logic [COORD_W-1:0]  rd_y,
    output logic [1:0]          rd_rot,
    output logic [2:0]          active_id,
    output logic                upd_pulse,
    output logic                busy
);

    localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int SW   = COORD_W + 1;

    typedef logic signed [SW-1:0] scoord_t;

    localparam scoord_t    STEP_S  = scoord_t'(STEP_PX);
    localparam scoord_t    XMIN_S  = scoord_t'(X_MIN);
    localparam scoord_t    XMAX_S  = scoord_t'(X_MAX);
    localparam scoord_t    YMIN_S  = scoord_t'(Y_MIN);
    localparam scoord_t    YMAX_S  = scoord_t'(Y_MAX);
    localparam logic [2:0] NONE_ID = 3'(N_PIECES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

    typedef enum logic {
        IDLE,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_PIECES-1:0] sel_meta;
    logic [N_PIECES-1:0] sel_sync;
    logic [3:0]          move_meta;
    logic [3:0]          move_sync;
    logic                rot_meta;
    logic                rot_sync;
    logic                rot_prev;
    logic                rot_edge;

    logic [2:0]          winner;
    logic                frame_accept;
    logic                commit;

    logic [FC_W-1:0]     frame_cnt;
    logic                frame_wrap;
    logic                step_due;
    logic [3:0]          move_snap;
    logic                rot_pend;

    logic [COORD_W-1:0]  x_tab   [N_PIECES];
    logic [COORD_W-1:0]  y_tab   [N_PIECES];
    logic [1:0]          rot_tab [N_PIECES];

    logic                active_valid;
    logic [2:0]          idx;
    logic [COORD_W-1:0]  cur_x;
    logic [COORD_W-1:0]  cur_y;
    logic [1:0]          cur_rot;
    scoord_t             sum_x;
    scoord_t             sum_y;
    logic [COORD_W-1:0]  new_x;
    logic [COORD_W-1:0]  new_y;
    logic [1:0]          new_rot;
    logic                entry_changed;

    function automatic logic [COORD_W-1:0] clamp(input scoord_t v, input scoord_t lo,
                                                 input scoord_t hi);
        if (v < lo) begin
            return lo[COORD_W-1:0];
        end else if (v > hi) begin
            return hi[COORD_W-1:0];
        end
        return v[COORD_W-1:0];
    endfunction

    // Board inputs are asynchronous; the rotate edge is taken on the synchronized level.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sel_meta  <= '0;
            sel_sync  <= '0;
            move_meta <= '0;
            move_sync <= '0;
            rot_meta  <= 1'b0;
            rot_sync  <= 1'b0;
            rot_prev  <= 1'b0;
        end else begin
            sel_meta  <= sel;
            sel_sync  <= sel_meta;
            move_meta <= move;
            move_sync <= move_meta;
            rot_meta  <= rotate;
            rot_sync  <= rot_meta;
            rot_prev  <= rot_sync;
        end
    end

    assign rot_edge = rot_sync & ~rot_prev;

    always_comb begin
        winner = NONE_ID;
        for (int i = N_PIECES - 1; i >= 0; i--) begin
            if (sel_sync[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_start) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A frame_start arriving while in COMMIT is dropped entirely, including the frame count.
    always_comb begin
        busy         = (state == COMMIT);
        commit       = (state == COMMIT);
        frame_accept = (state == IDLE) && frame_start;
    end

    assign frame_wrap = (frame_cnt == FC_LAST);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            frame_cnt <= '0;
            step_due  <= 1'b0;
            move_snap <= '0;
            active_id <= NONE_ID;
        end else if (frame_accept) begin
            frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            step_due  <= frame_wrap;
            move_snap <= move_sync;
            active_id <= winner;
        end
    end

    // A press landing in the COMMIT cycle itself is kept for the next frame rather than lost.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rot_pend <= 1'b0;
        end else if (rot_edge) begin
            rot_pend <= 1'b1;
        end else if (commit) begin
            rot_pend <= 1'b0;
        end
    end

    assign active_valid = (active_id < NONE_ID);
    assign idx          = active_valid ? active_id : 3'd0;

    always_comb begin
        cur_x   = x_tab[idx];
        cur_y   = y_tab[idx];
        cur_rot = rot_tab[idx];

        sum_x = $signed({1'b0, cur_x});
        sum_y = $signed({1'b0, cur_y});
        if (move_snap[0] && !move_snap[1]) begin
            sum_x = sum_x + STEP_S;
        end else if (move_snap[1] && !move_snap[0]) begin
            sum_x = sum_x - STEP_S;
        end
        if (move_snap[3] && !move_snap[2]) begin
            sum_y = sum_y - STEP_S;
        end else if (move_snap[2] && !move_snap[3]) begin
            sum_y = sum_y + STEP_S;
        end

        new_x   = step_due ? clamp(sum_x, XMIN_S, XMAX_S) : cur_x;
        new_y   = step_due ? clamp(sum_y, YMIN_S, YMAX_S) : cur_y;
        new_rot = rot_pend ? cur_rot + 2'd1 : cur_rot;

        entry_changed = active_valid &&
                        ((new_x != cur_x) || (new_y != cur_y) || (new_rot != cur_rot));
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < N_PIECES; i++) begin
                x_tab[i]   <= COORD_W'(X_MIN + i * INIT_PITCH);
                y_tab[i]   <= COORD_W'(Y_MIN);
                rot_tab[i] <= 2'd0;
            end
            upd_pulse <= 1'b0;
        end else begin
            upd_pulse <= commit && entry_changed;
            if (commit && active_valid) begin
                x_tab[idx]   <= new_x;
                y_tab[idx]   <= new_y;
                rot_tab[idx] <= new_rot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rd_x   <= '0;
            rd_y   <= '0;
            rd_rot <= '0;
        end else if (rd_id < NONE_ID) begin
            rd_x   <= x_tab[rd_id];
            rd_y   <= y_tab[rd_id];
            rd_rot <= rot_tab[rd_id];
        end else begin
            rd_x   <= '0;
            rd_y   <= '0;
            rd_rot <= '0;
        end
    end

endmodule

// File: tb/tb_tangram_move_ctrl.sv
// Self-checking bench for tangram_move_ctrl: fixed vector table, directed corner sequences,
// and randomized frames checked against a frame-level model of the piece table.
module tb_tangram_move_ctrl;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        frame_start;
    logic [6:0]  sel_in;
    logic [3:0]  move_in;
    logic        rotate;
    logic [2:0]  rd_id;
    logic [10:0] rd_x;
    logic [10:0] rd_y;
    logic [1:0]  rd_rot;
    logic [2:0]  active_id;
    logic        upd_pulse;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [6:0] sel;
        logic [3:0] mv;
        int         presses;
        int         chk_id;
        int         ex_act;
        int         ex_x;
        int         ex_y;
        int         ex_rot;
        int         ex_upd;
    } vec_t;

    vec_t tbl[20];

    int mx[7];
    int my[7];
    int mr[7];
    int mfcnt;
    bit mrp;

    tangram_move_ctrl dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .frame_start(frame_start),
        .sel        (sel_in),
        .move       (move_in),
        .rotate     (rotate),
        .rd_id      (rd_id),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_rot     (rd_rot),
        .active_id  (active_id),
        .upd_pulse  (upd_pulse),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        clr_n       = 1'b0;
        frame_start = 1'b0;
        sel_in      = '0;
        move_in     = '0;
        rotate      = 1'b0;
        rd_id       = 3'd3;
        repeat (3) tick();
        clr_n = 1'b1;
        tick();
    endtask

    task automatic read_entry(input int id, output int x, output int y, output int r);
        rd_id = 3'(id);
        tick();
        x = int'(rd_x);
        y = int'(rd_y);
        r = int'(rd_rot);
    endtask

    task automatic check_entry(input string name, input int id, input int ex, input int ey,
                               input int er);
        int x, y, r;
        read_entry(id, x, y, r);
        checkOutput({name, "_x"}, x, ex);
        checkOutput({name, "_y"}, y, ey);
        checkOutput({name, "_rot"}, r, er);
    endtask

    // One frame: settle inputs through the synchronizers, press rotate, then pulse frame_start.
    task automatic applyStimulus(input logic [6:0] s, input logic [3:0] mv, input int presses,
                                 output logic busy_seen, output logic upd_seen);
        sel_in  = s;
        move_in = mv;
        repeat (4) tick();
        for (int p = 0; p < presses; p++) begin
            rotate = 1'b1;
            repeat (3) tick();
            rotate = 1'b0;
            repeat (3) tick();
        end
        repeat (3) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        busy_seen   = busy;
        tick();
        upd_seen = upd_pulse;
        tick();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 7; i++) begin
            mx[i] = i * 100;
            my[i] = 0;
            mr[i] = 0;
        end
        mfcnt = 0;
        mrp   = 1'b0;
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Frame-level model: returns expected active piece and whether its entry changed.
    task automatic model_frame(input logic [6:0] s, input logic [3:0] mv, input int presses,
                               output int act, output int upd);
        bit due;
        int nx, ny, nr;
        if (presses > 0) mrp = 1'b1;
        mfcnt = (mfcnt + 1) % 4;
        due   = (mfcnt == 0);
        act   = 7;
        for (int i = 6; i >= 0; i--) begin
            if (s[i]) act = i;
        end
        upd = 0;
        if (act < 7) begin
            nx = mx[act];
            ny = my[act];
            nr = mr[act];
            if (due) begin
                if (mv[0] && !mv[1]) nx = nx + 4;
                if (mv[1] && !mv[0]) nx = nx - 4;
                if (mv[3] && !mv[2]) ny = ny - 4;
                if (mv[2] && !mv[3]) ny = ny + 4;
                nx = clampi(nx, 0, 760);
                ny = clampi(ny, 0, 560);
            end
            if (mrp) nr = (nr + 1) % 4;
            upd = (nx != mx[act] || ny != my[act] || nr != mr[act]) ? 1 : 0;
            mx[act] = nx;
            my[act] = ny;
            mr[act] = nr;
        end
        mrp = 1'b0;
    endtask

    initial begin
        logic b, u;
        int   x, y, r;
        int   pulses;
        int   act_e, upd_e;
        logic [6:0] rs;
        logic [3:0] rm;
        int   rp;

        tbl[0]  = '{7'b0000100, 4'b0001, 0, 2, 2, 200, 0, 0, 0};
        tbl[1]  = '{7'b0000100, 4'b0001, 0, 2, 2, 200, 0, 0, 0};
        tbl[2]  = '{7'b0000100, 4'b0001, 0, 2, 2, 200, 0, 0, 0};
        tbl[3]  = '{7'b0000100, 4'b0001, 0, 2, 2, 204, 0, 0, 1};
        tbl[4]  = '{7'b0000110, 4'b0001, 1, 1, 1, 100, 0, 1, 1};
        tbl[5]  = '{7'b0000110, 4'b0100, 0, 1, 1, 100, 0, 1, 0};
        tbl[6]  = '{7'b0000000, 4'b0000, 2, 1, 7, 100, 0, 1, 0};
        tbl[7]  = '{7'b0000001, 4'b0010, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{7'b0000001, 4'b0010, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{7'b0000001, 4'b0010, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{7'b0000001, 4'b0010, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{7'b0000001, 4'b1000, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{7'b1000000, 4'b0101, 3, 6, 6, 600, 0, 1, 1};
        tbl[13] = '{7'b1000000, 4'b0101, 0, 6, 6, 600, 0, 1, 0};
        tbl[14] = '{7'b1000000, 4'b0101, 0, 6, 6, 600, 0, 1, 0};
        tbl[15] = '{7'b1000000, 4'b0101, 0, 6, 6, 604, 4, 1, 1};
        tbl[16] = '{7'b1000000, 4'b1111, 0, 6, 6, 604, 4, 1, 0};
        tbl[17] = '{7'b1000000, 4'b1111, 0, 6, 6, 604, 4, 1, 0};
        tbl[18] = '{7'b1000000, 4'b1111, 0, 6, 6, 604, 4, 1, 0};
        tbl[19] = '{7'b1000000, 4'b1111, 0, 6, 6, 604, 4, 1, 0};

        clr_n       = 1'b0;
        frame_start = 1'b0;
        sel_in      = '0;
        move_in     = '0;
        rotate      = 1'b0;
        rd_id       = 3'd3;
        tick();

        // Reset state and initial layout
        do_reset();
        checkOutput("reset_active", int'(active_id), 7);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_upd", int'(upd_pulse), 0);
        for (int i = 0; i < 7; i++) begin
            check_entry($sformatf("init%0d", i), i, i * 100, 0, 0);
        end
        check_entry("rd_none", 7, 0, 0, 0);

        // Table-driven frames from a fresh reset
        do_reset();
        for (int v = 0; v < 20; v++) begin
            applyStimulus(tbl[v].sel, tbl[v].mv, tbl[v].presses, b, u);
            checkOutput($sformatf("tbl%0d_busy", v), int'(b), 1);
            checkOutput($sformatf("tbl%0d_upd", v), int'(u), tbl[v].ex_upd);
            checkOutput($sformatf("tbl%0d_active", v), int'(active_id), tbl[v].ex_act);
            check_entry($sformatf("tbl%0d", v), tbl[v].chk_id, tbl[v].ex_x, tbl[v].ex_y,
                        tbl[v].ex_rot);
        end

        // Piece 2 moving right for 8 frames: steps after frames 4 and 8
        do_reset();
        pulses = 0;
        for (int f = 1; f <= 8; f++) begin
            applyStimulus(7'b0000100, 4'b0001, 0, b, u);
            if (u) pulses++;
            if (f == 4) check_entry("step4", 2, 204, 0, 0);
        end
        checkOutput("step8_active", int'(active_id), 2);
        checkOutput("step8_pulses", pulses, 2);
        check_entry("step8", 2, 208, 0, 0);

        // Priority, then a selection change mid-frame must wait for the next frame_start
        applyStimulus(7'b0000110, 4'b0000, 0, b, u);
        checkOutput("prio_active", int'(active_id), 1);
        sel_in = 7'b0000001;
        repeat (10) tick();
        checkOutput("midframe_active", int'(active_id), 1);
        applyStimulus(7'b0000001, 4'b0000, 0, b, u);
        checkOutput("nextframe_active", int'(active_id), 0);

        // Rotation wraps 3 -> 0 over four frames
        do_reset();
        for (int f = 1; f <= 4; f++) begin
            applyStimulus(7'b0001000, 4'b0000, 1, b, u);
            checkOutput($sformatf("wrap%0d_upd", f), int'(u), 1);
            check_entry($sformatf("wrap%0d", f), 3, 300, 0, f % 4);
        end

        // Reset asserted during the COMMIT of a step frame with a pending rotation
        do_reset();
        for (int f = 1; f <= 3; f++) begin
            applyStimulus(7'b0000100, 4'b0001, 0, b, u);
        end
        rotate = 1'b1;
        repeat (3) tick();
        rotate = 1'b0;
        repeat (6) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checkOutput("abort_busy", int'(busy), 1);
        clr_n = 1'b0;
        tick();
        clr_n  = 1'b1;
        sel_in = '0;
        pulses = 0;
        repeat (5) begin
            if (upd_pulse) pulses++;
            tick();
        end
        checkOutput("abort_upd", pulses, 0);
        checkOutput("abort_active", int'(active_id), 7);
        check_entry("abort_p2", 2, 200, 0, 0);

        // Randomized frames against the frame-level model
        do_reset();
        model_reset();
        for (int f = 0; f < 40; f++) begin
            rs = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) rs = '0;
            rm = 4'($urandom_range(0, 15));
            rp = $urandom_range(0, 2);
            applyStimulus(rs, rm, rp, b, u);
            model_frame(rs, rm, rp, act_e, upd_e);
            checkOutput($sformatf("rnd%0d_busy", f), int'(b), 1);
            checkOutput($sformatf("rnd%0d_active", f), int'(active_id), act_e);
            checkOutput($sformatf("rnd%0d_upd", f), int'(u), upd_e);
            for (int i = 0; i < 7; i++) begin
                read_entry(i, x, y, r);
                checkOutput($sformatf("rnd%0d_p%0d_x", f, i), x, mx[i]);
                checkOutput($sformatf("rnd%0d_p%0d_y", f, i), y, my[i]);
                checkOutput($sformatf("rnd%0d_p%0d_rot", f, i), r, mr[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
